fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 34 +++
 rtl/fetch_unit_pc_counter.sv | 59 +++++
 rtl/fetch_unit.sv | 96 +++++++++
 tb/tb_fetch_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the fetch unit:
//   - default address/data widths (32-word memory, 8-bit instruction words)
//   - opcode encodings, which live in the top 3 bits of an instruction word
//   - saturating 8-bit counter helper used for the fetch counter
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

    localparam int AWIDTH_DEF = 5;
    localparam int DWIDTH_DEF = 8;
    localparam int OP_W       = 3;
    localparam int CNT_W      = 8;

    typedef enum logic [OP_W-1:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_e;

    // Increment that sticks at all-ones instead of rolling over.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        if (val == {CNT_W{1'b1}}) begin
            return val;
        end
        return val + CNT_W'(1);
    endfunction

endpackage

// File: rtl/fetch_unit_pc_counter.sv
// -----------------------------------------------------------------------------
// pc_counter
// Program counter with hold, load and increment, plus a one-cycle wrap pulse.
// Priority per edge: rst > hold > load > inc > keep.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset (PC=0, wrap=0)
//   hold_i     in   freeze the PC (load/inc ignored)
//   load_i     in   load PC from load_val_i
//   load_val_i in   AWIDTH value to load
//   inc_i      in   PC <= PC+1 modulo 2^AWIDTH
//   pc_o       out  current PC
//   wrap_o     out  high for the cycle after an increment from all-ones to 0
// -----------------------------------------------------------------------------
module pc_counter #(
    parameter int AWIDTH = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold_i,
    input  logic              load_i,
    input  logic [AWIDTH-1:0] load_val_i,
    input  logic              inc_i,
    output logic [AWIDTH-1:0] pc_o,
    output logic              wrap_o
);

    logic [AWIDTH-1:0] pc_q, pc_d;
    logic              wrap_q, wrap_d;

    always_comb begin
        pc_d   = pc_q;
        wrap_d = 1'b0;
        if (!hold_i) begin
            if (load_i) begin
                // A load wins over a simultaneous increment; a load to 0 is
                // not a wrap.
                pc_d = load_val_i;
            end else if (inc_i) begin
                pc_d   = pc_q + AWIDTH'(1);
                wrap_d = (pc_q == {AWIDTH{1'b1}});
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= '0;
            wrap_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            wrap_q <= wrap_d;
        end
    end

    assign pc_o   = pc_q;
    assign wrap_o = wrap_q;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch datapath: instruction register, program counter, sticky
// halt flag, saturating fetch counter and the memory address mux.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset, overrides everything
//   data       in   DWIDTH instruction word from memory
//   ld_ir      in   capture data into the IR
//   ld_pc      in   load PC from the IR operand address (value before the edge)
//   inc_pc     in   increment PC
//   halt       in   stop request; sets the sticky halted flag
//   sel        in   address select: 1 = PC, 0 = IR operand
//   opcode     out  IR top 3 bits
//   ir_addr    out  IR low AWIDTH bits
//   pc_addr    out  current PC
//   addr       out  combinational memory address
//   halted     out  sticky halted flag (cleared only by rst)
//   pc_wrap    out  one-cycle pulse after the PC wraps by increment
//   instr_cnt  out  count of accepted IR loads, saturating at 255
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int DWIDTH = DWIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] data,
    input  logic              ld_ir,
    input  logic              ld_pc,
    input  logic              inc_pc,
    input  logic              halt,
    input  logic              sel,
    output logic [OP_W-1:0]   opcode,
    output logic [AWIDTH-1:0] ir_addr,
    output logic [AWIDTH-1:0] pc_addr,
    output logic [AWIDTH-1:0] addr,
    output logic              halted,
    output logic              pc_wrap,
    output logic [CNT_W-1:0]  instr_cnt
);

    logic [DWIDTH-1:0] ir_q, ir_d;
    logic              halted_q, halted_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              freeze;
    logic              accept;

    // The halt edge itself already freezes state, not only the cycles after.
    assign freeze = halted_q | halt;
    assign accept = ld_ir & ~freeze;

    always_comb begin
        ir_d     = ir_q;
        cnt_d    = cnt_q;
        halted_d = halted_q | halt;
        if (accept) begin
            ir_d  = data;
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q     <= '0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            ir_q     <= ir_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    pc_counter #(
        .AWIDTH (AWIDTH)
    ) u_pc (
        .clk        (clk),
        .rst        (rst),
        .hold_i     (freeze),
        .load_i     (ld_pc),
        .load_val_i (ir_q[AWIDTH-1:0]),
        .inc_i      (inc_pc),
        .pc_o       (pc_addr),
        .wrap_o     (pc_wrap)
    );

    assign opcode    = ir_q[DWIDTH-1 -: OP_W];
    assign ir_addr   = ir_q[AWIDTH-1:0];
    assign addr      = sel ? pc_addr : ir_addr;
    assign halted    = halted_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed vector table for fetch_unit, followed by hand-written sequences
// for counter saturation and reset in the middle of a fetch train.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int AW = 5;
  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic [DW-1:0] data;
  logic          ld_ir;
  logic          ld_pc;
  logic          inc_pc;
  logic          halt;
  logic          sel;
  logic [2:0]    opcode;
  logic [AW-1:0] ir_addr;
  logic [AW-1:0] pc_addr;
  logic [AW-1:0] addr;
  logic          halted;
  logic          pc_wrap;
  logic [7:0]    instr_cnt;

  int checks;
  int errors;

  logic [7:0] exp_q[$];

  typedef struct {
    logic          rst;
    logic [DW-1:0] data;
    logic          ld_ir;
    logic          ld_pc;
    logic          inc_pc;
    logic          halt;
    logic          sel;
    logic [2:0]    e_op;
    logic [AW-1:0] e_ira;
    logic [AW-1:0] e_pc;
    logic          e_halt;
    logic          e_wrap;
    logic [7:0]    e_cnt;
  } vec_t;

  vec_t vecs[$];

  fetch_unit #(
    .AWIDTH (AW),
    .DWIDTH (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data      (data),
    .ld_ir     (ld_ir),
    .ld_pc     (ld_pc),
    .inc_pc    (inc_pc),
    .halt      (halt),
    .sel       (sel),
    .opcode    (opcode),
    .ir_addr   (ir_addr),
    .pc_addr   (pc_addr),
    .addr      (addr),
    .halted    (halted),
    .pc_wrap   (pc_wrap),
    .instr_cnt (instr_cnt)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst    = 1'b1;
    data   = '0;
    ld_ir  = 1'b0;
    ld_pc  = 1'b0;
    inc_pc = 1'b0;
    halt   = 1'b0;
    sel    = 1'b1;
  end

  // driver tasks
  task automatic drive(input logic r, input logic [DW-1:0] d, input logic li,
                       input logic lp, input logic ip, input logic h, input logic s);
    rst    = r;
    data   = d;
    ld_ir  = li;
    ld_pc  = lp;
    inc_pc = ip;
    halt   = h;
    sel    = s;
  endtask

  // apply for one edge, outputs are sampled 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [DW-1:0] d, input logic li,
                              input logic lp, input logic ip, input logic h, input logic s,
                              input logic [2:0] op, input logic [AW-1:0] ira,
                              input logic [AW-1:0] pc, input logic hl, input logic w,
                              input logic [7:0] cnt);
    vec_t v;
    v.rst = r; v.data = d; v.ld_ir = li; v.ld_pc = lp; v.inc_pc = ip;
    v.halt = h; v.sel = s;
    v.e_op = op; v.e_ira = ira; v.e_pc = pc; v.e_halt = hl; v.e_wrap = w;
    v.e_cnt = cnt;
    return v;
  endfunction

  initial begin : main
    logic [7:0] model_cnt;
    logic [7:0] exp_cnt;
    logic [DW-1:0] last_d;
    checks = 0;
    errors = 0;

    //                 rst data   li lp ip h  s   op ira pc hlt w cnt
    vecs.push_back(mk(1, 8'h00, 0, 0, 0, 0, 1,  0,  0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 8'hE5, 1, 0, 0, 0, 1,  7,  5,  0, 0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0, 1,  7,  5,  5, 0, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0,  7,  5,  5, 0, 0, 1));
    vecs.push_back(mk(0, 8'h2C, 1, 0, 0, 0, 0,  1, 12,  5, 0, 0, 2));
    vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0, 1,  1, 12, 12, 0, 0, 2));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 1,  1, 12, 13, 0, 0, 2));
    vecs.push_back(mk(0, 8'h1E, 1, 0, 0, 0, 0,  0, 30, 13, 0, 0, 3));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0, 1,  0, 30, 30, 0, 0, 3));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 1,  0, 30, 31, 0, 0, 3));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 1,  0, 30,  0, 0, 1, 3));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1,  0, 30,  0, 0, 0, 3));
    vecs.push_back(mk(0, 8'h1F, 1, 0, 0, 0, 0,  0, 31,  0, 0, 0, 4));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0, 1,  0, 31, 31, 0, 0, 4));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0,  0,  0, 31, 0, 0, 5));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0, 1,  0,  0,  0, 0, 0, 5));
    vecs.push_back(mk(1, 8'h00, 0, 0, 0, 0, 1,  0,  0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 1,  0,  0,  1, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 1,  0,  0,  2, 0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 1,  0,  0,  3, 0, 0, 0));
    vecs.push_back(mk(0, 8'hA9, 1, 0, 0, 0, 1,  5,  9,  3, 0, 0, 1));
    vecs.push_back(mk(0, 8'hFF, 1, 0, 1, 1, 1,  5,  9,  3, 1, 0, 1));
    vecs.push_back(mk(0, 8'hFF, 1, 0, 0, 0, 1,  5,  9,  3, 1, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0,  5,  9,  3, 1, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 1,  5,  9,  3, 1, 0, 1));
    vecs.push_back(mk(0, 8'h00, 0, 1, 1, 1, 1,  5,  9,  3, 1, 0, 1));
    vecs.push_back(mk(1, 8'hFF, 1, 0, 1, 0, 1,  0,  0,  0, 0, 0, 0));
    vecs.push_back(mk(0, 8'h47, 1, 0, 0, 0, 0,  2,  7,  0, 0, 0, 1));

    @(negedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].data, vecs[i].ld_ir, vecs[i].ld_pc,
            vecs[i].inc_pc, vecs[i].halt, vecs[i].sel);
      step();
      check($sformatf("v%0d opcode", i), int'(opcode), int'(vecs[i].e_op));
      check($sformatf("v%0d ir_addr", i), int'(ir_addr), int'(vecs[i].e_ira));
      check($sformatf("v%0d pc_addr", i), int'(pc_addr), int'(vecs[i].e_pc));
      check($sformatf("v%0d addr", i), int'(addr),
            vecs[i].sel ? int'(vecs[i].e_pc) : int'(vecs[i].e_ira));
      check($sformatf("v%0d halted", i), int'(halted), int'(vecs[i].e_halt));
      check($sformatf("v%0d pc_wrap", i), int'(pc_wrap), int'(vecs[i].e_wrap));
      check($sformatf("v%0d instr_cnt", i), int'(instr_cnt), int'(vecs[i].e_cnt));
    end

    // 256+ consecutive fetches: counter climbs and sticks at 255
    drive(1, 8'h00, 0, 0, 0, 0, 1);
    step();
    model_cnt = 8'd0;
    check("sat reset cnt", int'(instr_cnt), 0);
    last_d = '0;
    for (int i = 0; i < 260; i++) begin
      last_d = DW'(i * 7 + 3);
      drive(0, last_d, 1, 0, 0, 0, 1);
      if (model_cnt != 8'd255) model_cnt = model_cnt + 8'd1;
      exp_q.push_back(model_cnt);
      step();
      exp_cnt = exp_q.pop_front();
      check($sformatf("sat cnt %0d", i), int'(instr_cnt), int'(exp_cnt));
    end
    check("sat last opcode", int'(opcode), int'(last_d[DW-1 -: 3]));
    check("sat last ir_addr", int'(ir_addr), int'(last_d[AW-1:0]));
    check("sat final cnt", int'(instr_cnt), 255);

    // rst in the middle of a fetch train wins over ld_ir
    drive(1, 8'h00, 0, 0, 0, 0, 1);
    step();
    for (int i = 0; i < 10; i++) begin
      drive(0, 8'h65, 1, 0, 0, 0, 1);
      step();
    end
    check("train cnt", int'(instr_cnt), 10);
    drive(1, 8'hE3, 1, 0, 1, 0, 1);
    step();
    check("train rst cnt", int'(instr_cnt), 0);
    check("train rst opcode", int'(opcode), 0);
    check("train rst addr", int'(addr), 0);
    drive(0, 8'hE3, 1, 0, 0, 0, 0);
    step();
    check("train resume cnt", int'(instr_cnt), 1);
    check("train resume addr", int'(addr), 3);
    drive(0, 8'h00, 0, 0, 0, 0, 1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // global watchdog so the bench always terminates
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
